// File: rtl/cla_group_serial_addsub_pkg.sv
// Shared types and constants for the group-serial lookahead adder/subtractor.
package cla_group_serial_addsub_pkg;

  localparam int GRP_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/cla_group_serial_addsub_nibble.sv
// One 4-bit carry-lookahead slice: per-bit g/p, sums of products for c1..c4.
module cla_nibble_slice
  import cla_group_serial_addsub_pkg::*;
(
  input  logic [GRP_W-1:0] a4,
  input  logic [GRP_W-1:0] b4,
  input  logic             cin,
  output logic [GRP_W-1:0] sum4,
  output logic             c4,
  output logic             c3,
  output logic             gout,
  output logic             pout
);

  logic [GRP_W-1:0] p;
  logic [GRP_W-1:0] g;
  logic [GRP_W-1:0] c;

  always_comb begin
    p = a4 ^ b4;
    g = a4 & b4;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0])
         | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1])
         | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & cin);
    gout = g[3] | (p[3] & g[2])
         | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]);
    pout = &p;
    c4   = gout | (pout & cin);
    c3   = c[3];
    sum4 = p ^ c;
  end

endmodule

// File: rtl/cla_group_serial_addsub.sv
// Group-serial add/sub reusing one 4-bit lookahead slice per cycle.
// Optional early completion: CLA_SERIAL_EARLY_DONE_EN.
module cla_group_serial_addsub
  import cla_group_serial_addsub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NGRP  = WIDTH / GRP_W;
  localparam int IDX_W = (NGRP > 1) ? clog2(NGRP) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NGRP - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [GRP_W-1:0] a_grp, b_grp, s_sum;
  logic             s_c4, s_c3, s_g, s_p;

  always_comb begin
    a_grp = a_q[GRP_W*int'(idx_q) +: GRP_W];
    b_grp = b_q[GRP_W*int'(idx_q) +: GRP_W];
  end

  cla_nibble_slice u_slice (
    .a4   (a_grp),
    .b4   (b_grp),
    .cin  (carry_q),
    .sum4 (s_sum),
    .c4   (s_c4),
    .c3   (s_c3),
    .gout (s_g),
    .pout (s_p)
  );

`ifdef CLA_SERIAL_EARLY_DONE_EN
  logic rest_zero;
  always_comb begin
    rest_zero = ((a_q | b_q) >> (GRP_W * (int'(idx_q) + 1))) == '0;
  end
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub;
          idx_d   = '0;
          sum_d   = '0;
          state_d = ST_COMPUTE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_COMPUTE: begin
        sum_d[GRP_W*int'(idx_q) +: GRP_W] = s_sum;
        carry_d = s_g | (s_p & carry_q);
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == LAST) begin
          cout_d  = s_c4;
          ovf_d   = s_c3 ^ s_c4;
          state_d = ST_DONE;
`ifdef CLA_SERIAL_EARLY_DONE_EN
        end else if (!s_c4 && rest_zero) begin
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          state_d = ST_DONE;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ready = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign busy  = (state_q == ST_COMPUTE);
  assign done  = (state_q == ST_DONE);
  assign sum   = sum_q;
  assign cout  = cout_q;
  assign ovf   = ovf_q;

endmodule
